// File: rtl/dma_vp_cmd_sched.sv
// In-order job scheduler: queues host descriptors, issues one DMA/VP job at a time,
// waits for its done pulse (or timeout) and keeps sticky error flags and a done counter.
module dma_vp_cmd_sched #(
  parameter int DEPTH = 4,
  parameter int TO_W  = 20
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clk_en,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [1:0]               cmd_op,
  input  logic [31:0]              cmd_spm_ptr,
  input  logic [63:0]              cmd_ddr_ptr,
  input  logic [31:0]              cmd_size,
  input  logic [10:0]              cmd_poly_id,
  input  logic                     abort,
  input  logic                     err_clr,
  output logic                     dma_rd_start,
  output logic                     dma_wr_start,
  output logic                     vp_start,
  output logic [63:0]              base_addr,
  output logic [63:0]              data_ptr,
  output logic [31:0]              data_size_bytes,
  output logic [10:0]              poly_id,
  output logic [31:0]              vp_pc,
  input  logic                     dma_rd_done,
  input  logic                     dma_wr_done,
  input  logic                     vp_done,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   q_count,
  output logic                     err_timeout,
  output logic                     err_op,
  output logic [15:0]              done_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int DW = 2 + 32 + 64 + 32 + 11;

  localparam logic [1:0] OP_RD  = 2'd0;
  localparam logic [1:0] OP_WR  = 2'd1;
  localparam logic [1:0] OP_VP  = 2'd2;
  localparam logic [1:0] OP_BAD = 2'd3;

  // Last counter value before the terminal count 2^TO_W-1.
  localparam logic [TO_W-1:0] TO_LAST = {{(TO_W-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic [DW-1:0]   mem [DEPTH];
  logic [PW-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]   count_reg;

  logic [1:0]      op_reg;
  logic [31:0]     spm_reg;
  logic [63:0]     ddr_reg;
  logic [31:0]     size_reg;
  logic [10:0]     poly_reg;
  logic [TO_W-1:0] to_cnt_reg;
  logic [15:0]     done_cnt_reg;
  logic            err_timeout_reg;
  logic            err_op_reg;

  logic [DW-1:0]   head;
  logic [1:0]      head_op;
  logic            abort_en;
  logic            push;
  logic            pop;
  logic            done_match;
  logic            accept;
  logic            to_hit;
  logic            timeout;

  assign cmd_ready = (count_reg < CW'(DEPTH));

  always_comb begin
    abort_en   = clk_en & abort;
    head       = mem[rd_ptr_reg];
    head_op    = head[DW-1 -: 2];
    push       = clk_en & cmd_valid & cmd_ready & ~abort;
    pop        = clk_en & ~abort & (state_reg == IDLE) & (count_reg != '0);
    done_match = ((op_reg == OP_RD) & dma_rd_done) |
                 ((op_reg == OP_WR) & dma_wr_done) |
                 ((op_reg == OP_VP) & vp_done);
    accept     = clk_en & ~abort & (state_reg != IDLE) & done_match;
    to_hit     = (to_cnt_reg == TO_LAST);
    timeout    = clk_en & ~abort & (state_reg == WAIT) & ~done_match & to_hit;

    state_next = state_reg;
    if (abort_en) begin
      state_next = IDLE;
    end else if (clk_en) begin
      case (state_reg)
        IDLE:    if (pop && head_op != OP_BAD) state_next = ISSUE;
        ISSUE:   state_next = done_match ? IDLE : WAIT;
        WAIT:    if (done_match || to_hit) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end

    // Start pulses follow the ISSUE state so they hold while clk_en is low.
    dma_rd_start = (state_reg == ISSUE) & ~abort_en & (op_reg == OP_RD);
    dma_wr_start = (state_reg == ISSUE) & ~abort_en & (op_reg == OP_WR);
    vp_start     = (state_reg == ISSUE) & ~abort_en & (op_reg == OP_VP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= {cmd_op, cmd_spm_ptr, cmd_ddr_ptr, cmd_size, cmd_poly_id};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (abort_en) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_reg   <= '0;
      spm_reg  <= '0;
      ddr_reg  <= '0;
      size_reg <= '0;
      poly_reg <= '0;
    end else if (pop) begin
      op_reg   <= head_op;
      spm_reg  <= head[138:107];
      ddr_reg  <= head[106:43];
      size_reg <= head[42:11];
      poly_reg <= (head_op == OP_RD) ? head[10:0] : 11'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_reg      <= '0;
      done_cnt_reg    <= '0;
      err_timeout_reg <= 1'b0;
      err_op_reg      <= 1'b0;
    end else if (clk_en) begin
      if (pop)
        to_cnt_reg <= '0;
      else if (state_reg == WAIT && !abort)
        to_cnt_reg <= to_cnt_reg + TO_W'(1);

      if (accept) done_cnt_reg <= done_cnt_reg + 16'd1;

      // A new error outranks a simultaneous clear.
      if (timeout)      err_timeout_reg <= 1'b1;
      else if (err_clr) err_timeout_reg <= 1'b0;

      if (pop && head_op == OP_BAD) err_op_reg <= 1'b1;
      else if (err_clr)             err_op_reg <= 1'b0;
    end
  end

  assign base_addr       = {32'b0, spm_reg};
  assign data_ptr        = ddr_reg;
  assign data_size_bytes = size_reg;
  assign poly_id         = poly_reg;
  assign vp_pc           = spm_reg;
  assign busy            = (state_reg != IDLE) | (count_reg != '0);
  assign q_count         = count_reg;
  assign err_timeout     = err_timeout_reg;
  assign err_op          = err_op_reg;
  assign done_cnt        = done_cnt_reg;

endmodule

// File: tb/tb_dma_vp_cmd_sched.sv
// Directed bench for dma_vp_cmd_sched with DEPTH=4, TO_W=4.
module tb_dma_vp_cmd_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clk_en;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [31:0] cmd_spm_ptr;
  logic [63:0] cmd_ddr_ptr;
  logic [31:0] cmd_size;
  logic [10:0] cmd_poly_id;
  logic        abort;
  logic        err_clr;
  logic        dma_rd_start, dma_wr_start, vp_start;
  logic [63:0] base_addr;
  logic [63:0] data_ptr;
  logic [31:0] data_size_bytes;
  logic [10:0] poly_id;
  logic [31:0] vp_pc;
  logic        dma_rd_done, dma_wr_done, vp_done;
  logic        busy;
  logic [2:0]  q_count;
  logic        err_timeout, err_op;
  logic [15:0] done_cnt;

  int vectors = 0;
  int miscompares = 0;

  dma_vp_cmd_sched #(.DEPTH(4), .TO_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_spm_ptr(cmd_spm_ptr), .cmd_ddr_ptr(cmd_ddr_ptr), .cmd_size(cmd_size),
    .cmd_poly_id(cmd_poly_id), .abort(abort), .err_clr(err_clr),
    .dma_rd_start(dma_rd_start), .dma_wr_start(dma_wr_start), .vp_start(vp_start),
    .base_addr(base_addr), .data_ptr(data_ptr), .data_size_bytes(data_size_bytes),
    .poly_id(poly_id), .vp_pc(vp_pc),
    .dma_rd_done(dma_rd_done), .dma_wr_done(dma_wr_done), .vp_done(vp_done),
    .busy(busy), .q_count(q_count), .err_timeout(err_timeout), .err_op(err_op),
    .done_cnt(done_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; single-cycle inputs drop right after it.
  task automatic tick();
    @(posedge clk);
    #1;
    cmd_valid   = 1'b0;
    abort       = 1'b0;
    err_clr     = 1'b0;
    dma_rd_done = 1'b0;
    dma_wr_done = 1'b0;
    vp_done     = 1'b0;
  endtask

  task automatic set_cmd(input logic [1:0] op, input logic [31:0] spm, input logic [63:0] ddr,
                         input logic [31:0] size, input logic [10:0] poly);
    cmd_valid   = 1'b1;
    cmd_op      = op;
    cmd_spm_ptr = spm;
    cmd_ddr_ptr = ddr;
    cmd_size    = size;
    cmd_poly_id = poly;
  endtask

  logic [2:0] starts;
  assign starts = {dma_rd_start, dma_wr_start, vp_start};

  initial begin
    rst_n = 1'b0; clk_en = 1'b1;
    cmd_valid = 1'b0; cmd_op = '0; cmd_spm_ptr = '0; cmd_ddr_ptr = '0; cmd_size = '0; cmd_poly_id = '0;
    abort = 1'b0; err_clr = 1'b0; dma_rd_done = 1'b0; dma_wr_done = 1'b0; vp_done = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    check("reset_ready", cmd_ready, 1);
    check("reset_qcount", q_count, 0);
    check("reset_busy", busy, 0);
    check("reset_starts", starts, 0);
    check("reset_done_cnt", done_cnt, 0);
    check("reset_errs", {err_timeout, err_op}, 0);
    check("reset_base", base_addr, 0);
    $display("reset done");

    // Single DMA_RD
    set_cmd(2'd0, 32'h100, 64'h1_0000_2000, 32'd4096, 11'd5);
    tick();
    check("rd_push_qcount", q_count, 1);
    check("rd_no_start_yet", starts, 0);
    tick();
    check("rd_start", starts, 3'b100);
    check("rd_poly", poly_id, 5);
    check("rd_base", base_addr, 64'h100);
    check("rd_ddr", data_ptr, 64'h1_0000_2000);
    check("rd_size", data_size_bytes, 4096);
    tick();
    check("rd_start_1cyc", starts, 0);
    repeat (8) tick();
    check("rd_busy_wait", busy, 1);
    dma_rd_done = 1'b1;
    tick();
    check("rd_done_cnt", done_cnt, 1);
    check("rd_busy_drop", busy, 0);
    $display("txn single DMA_RD: done_cnt=%0d", done_cnt);

    // Job in flight, then 4 back-to-back pushes fill the queue
    set_cmd(2'd1, 32'h200, 64'h3000, 32'd64, 11'd7);
    tick(); tick();
    check("j0_wr_start", starts, 3'b010);
    check("j0_poly_forced", poly_id, 0);
    tick();
    set_cmd(2'd1, 32'h11, 64'h1100, 32'd16, 11'd1); tick();
    set_cmd(2'd0, 32'h22, 64'h2200, 32'd32, 11'd9); tick();
    set_cmd(2'd2, 32'h33, 64'h3300, 32'd48, 11'd2); tick();
    set_cmd(2'd1, 32'h44, 64'h4400, 32'd80, 11'd3); tick();
    check("full_qcount", q_count, 4);
    check("full_ready_low", cmd_ready, 0);
    vp_done = 1'b1;
    tick();
    check("vp_done_ignored", done_cnt, 1);
    check("vp_done_ign_busy", busy, 1);
    dma_wr_done = 1'b1;
    tick();
    check("j0_done", done_cnt, 2);
    set_cmd(2'd0, 32'hBAD, 64'hBAD, 32'd1, 11'd1);
    tick();
    check("full_pop_qcount", q_count, 3);
    check("j1_start", starts, 3'b010);
    check("j1_base", base_addr, 64'h11);
    tick();
    check("j1_start_end", starts, 0);
    dma_wr_done = 1'b1; tick();
    tick();
    check("j2_start", starts, 3'b100);
    check("j2_poly", poly_id, 9);
    check("j2_base", base_addr, 64'h22);
    tick();
    dma_rd_done = 1'b1; tick();
    tick();
    check("j3_start", starts, 3'b001);
    check("j3_pc", vp_pc, 32'h33);
    check("j3_poly", poly_id, 0);
    tick();
    vp_done = 1'b1; tick();
    tick();
    check("j4_start", starts, 3'b010);
    check("j4_size", data_size_bytes, 80);
    tick();
    dma_wr_done = 1'b1; tick();
    check("j4_done_cnt", done_cnt, 6);
    tick();
    check("queue_drained", {busy, q_count}, 0);
    check("params_hold", base_addr, 64'h44);
    $display("txn back-to-back: done_cnt=%0d", done_cnt);

    // Illegal op followed by VP
    set_cmd(2'd3, 32'h55, 64'h55, 32'd1, 11'd1); tick();
    set_cmd(2'd2, 32'h66, 64'h66, 32'd1, 11'd1); tick();
    check("bad_err_op", err_op, 1);
    check("bad_no_start", starts, 0);
    check("bad_qcount", q_count, 1);
    tick();
    check("vp_after_bad", starts, 3'b001);
    check("vp_after_bad_pc", vp_pc, 32'h66);
    tick();
    err_clr = 1'b1; vp_done = 1'b1;
    tick();
    check("err_op_clr", err_op, 0);
    check("vp_done_cnt", done_cnt, 7);
    $display("txn illegal op: err_op cleared, done_cnt=%0d", done_cnt);

    // Timeout with TO_W=4: 15 WAIT cycles
    set_cmd(2'd0, 32'h77, 64'h77, 32'd8, 11'd4); tick();
    tick();
    check("to_start", starts, 3'b100);
    tick();
    repeat (14) tick();
    check("to_not_yet", {err_timeout, busy}, 2'b01);
    tick();
    check("to_err", err_timeout, 1);
    check("to_idle", busy, 0);
    check("to_done_cnt", done_cnt, 7);
    dma_rd_done = 1'b1; tick();
    check("to_late_done", done_cnt, 7);
    err_clr = 1'b1; tick();
    check("to_clr", err_timeout, 0);
    $display("txn timeout: err_timeout seen, done_cnt=%0d", done_cnt);

    // Abort in ISSUE suppresses the start pulse
    set_cmd(2'd0, 32'h90, 64'h90, 32'd8, 11'd4); tick();
    tick();
    check("ab_iss_start", starts, 3'b100);
    abort = 1'b1;
    #1;
    check("ab_iss_suppr", starts, 0);
    tick();
    check("ab_iss_idle", busy, 0);

    // Abort in WAIT with two queued jobs and a same-cycle push
    set_cmd(2'd1, 32'h81, 64'h81, 32'd8, 11'd0); tick();
    set_cmd(2'd0, 32'h82, 64'h82, 32'd8, 11'd0); tick();
    set_cmd(2'd2, 32'h83, 64'h83, 32'd8, 11'd0); tick();
    check("ab_q2", q_count, 2);
    check("ab_ready", cmd_ready, 1);
    abort = 1'b1;
    set_cmd(2'd2, 32'h84, 64'h84, 32'd8, 11'd0);
    tick();
    check("ab_qcount", q_count, 0);
    check("ab_busy", busy, 0);
    tick(); check("ab_nostart1", starts, 0);
    tick(); check("ab_nostart2", starts, 0);
    dma_wr_done = 1'b1; tick();
    check("ab_late_done", done_cnt, 7);
    $display("txn abort: q_count=%0d done_cnt=%0d", q_count, done_cnt);

    // Fresh push, with clk_en gating a handshake and stretching the start
    set_cmd(2'd2, 32'h99, 64'h99, 32'd8, 11'd0);
    clk_en = 1'b0;
    tick();
    check("en_no_push", q_count, 0);
    clk_en = 1'b1;
    set_cmd(2'd2, 32'h99, 64'h99, 32'd8, 11'd0);
    tick();
    check("en_push", q_count, 1);
    tick();
    check("fresh_start", starts, 3'b001);
    check("fresh_pc", vp_pc, 32'h99);
    clk_en = 1'b0;
    tick();
    check("en_hold_start", starts, 3'b001);
    clk_en = 1'b1;
    tick();
    check("en_start_end", starts, 0);
    vp_done = 1'b1; tick();
    check("fresh_done_cnt", done_cnt, 8);
    check("fresh_idle", busy, 0);
    $display("txn fresh push: done_cnt=%0d", done_cnt);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
